// File: rtl/core_inst_pkg.sv
// +-----------------------------------------------------------------------------+
// | core_inst_pkg : core instruction bit positions, sequencer states, idle word |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package core_inst_pkg;

  localparam int c_b_load     = 0;
  localparam int c_b_execute  = 1;
  localparam int c_b_l0_wr    = 2;
  localparam int c_b_l0_rd    = 3;
  localparam int c_b_ofifo_rd = 6;
  localparam int c_b_axmem_lo = 7;
  localparam int c_b_wen_xmem = 18;
  localparam int c_b_cen_xmem = 19;
  localparam int c_b_apmem_lo = 20;
  localparam int c_b_wen_pmem = 31;
  localparam int c_b_cen_pmem = 32;
  localparam int c_b_acc      = 33;
  localparam int c_b_sfu_pass = 34;
  localparam int c_b_relu     = 45;
  localparam int c_a_w        = 11;

  // Both memories deselected, xmem in read mode, nothing else active.
  localparam logic [63:0] c_inst_idle = (64'd1 << c_b_wen_xmem)
                                      | (64'd1 << c_b_cen_xmem)
                                      | (64'd1 << c_b_cen_pmem);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CLR   = 4'd1,
    S_WPRE  = 4'd2,
    S_W2L0  = 4'd3,
    S_KPRE  = 4'd4,
    S_KLOAD = 4'd5,
    S_GAP   = 4'd6,
    S_XPRE  = 4'd7,
    S_EXEC  = 4'd8,
    S_DRAIN = 4'd9,
    S_DONE  = 4'd10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/onij_map.sv
// +-----------------------------------------------------------------------------+
// | onij_map : input pixel (nx,ny) and kernel tap kij -> output psum address    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module onij_map #(
  parameter int OUT_W = 4,
  parameter int KW    = 3,
  parameter int XY_W  = 3,
  parameter int KIJ_W = 4,
  parameter int A_W   = 11
) (
  input  logic [XY_W-1:0]  nx,
  input  logic [XY_W-1:0]  ny,
  input  logic [KIJ_W-1:0] kij,
  output logic             valid,
  output logic [A_W-1:0]   a_pmem
);

  logic [KIJ_W-1:0] w_kx;
  logic [KIJ_W-1:0] w_ky;
  int               w_ox;
  int               w_oy;

  // Tap row/column by threshold compare so no divider is built.
  always_comb begin
    w_ky = '0;
    for (int i = 1; i < KW; i++) begin
      if (kij >= KIJ_W'(i * KW)) w_ky = KIJ_W'(i);
    end
    w_kx   = kij - KIJ_W'(KW) * w_ky;
    w_ox   = int'(nx) - int'(w_kx);
    w_oy   = int'(ny) - int'(w_ky);
    valid  = (w_ox >= 0) && (w_ox < OUT_W) && (w_oy >= 0) && (w_oy < OUT_W);
    a_pmem = valid ? A_W'(w_ox + w_oy * OUT_W) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
// +-----------------------------------------------------------------------------+
// | conv_seq_ctrl : drives core inst word through all 9 kij passes of one tile  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module conv_seq_ctrl
  import core_inst_pkg::*;
#(
  parameter int COL     = 8,
  parameter int ROW     = 8,
  parameter int LEN_NIJ = 36,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4,
  parameter int KW      = 3,
  parameter int LEN_KIJ = 9,
  parameter int WBASE   = 1024,
  parameter int CLR_CYC = 11,
  parameter int GAP_CYC = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        relu_en,
  input  logic        ofifo_valid,
  output logic [63:0] inst,
  output logic        core_clr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW    = $clog2(LEN_NIJ + COL + ROW + 1);
  localparam int KIJ_W = $clog2(LEN_KIJ);
  localparam int XY_W  = $clog2(IN_W);

  localparam logic [CW-1:0]    c_clr_end   = CW'(CLR_CYC);
  localparam logic [CW-1:0]    c_w2l0_end  = CW'(COL);
  localparam logic [CW-1:0]    c_wrow_last = CW'(COL - 1);
  localparam logic [CW-1:0]    c_kload_end = CW'(COL + ROW - 1);
  localparam logic [CW-1:0]    c_gap_end   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0]    c_exec_end  = CW'(LEN_NIJ + COL + ROW);
  localparam logic [CW-1:0]    c_nij       = CW'(LEN_NIJ);
  localparam logic [CW-1:0]    c_drain_end = CW'(1);
  localparam logic [KIJ_W-1:0] c_kij_last  = KIJ_W'(LEN_KIJ - 1);
  localparam logic [XY_W-1:0]  c_xy_last   = XY_W'(IN_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cyc;
  logic [KIJ_W-1:0] r_kij;
  logic [XY_W-1:0]  r_nx;
  logic [XY_W-1:0]  r_ny;
  logic             r_nij_full;
  logic             r_err;
  logic             r_relu_en;

  logic             w_acc_win;
  logic             w_consume;
  logic             w_overread;
  logic             w_map_valid;
  logic [c_a_w-1:0] w_map_addr;
  logic [c_a_w-1:0] w_wrow;
  logic [CW-1:0]    w_wofs;

  onij_map #(
    .OUT_W (OUT_W),
    .KW    (KW),
    .XY_W  (XY_W),
    .KIJ_W (KIJ_W),
    .A_W   (c_a_w)
  ) u_onij_map (
    .nx     (r_nx),
    .ny     (r_ny),
    .kij    (r_kij),
    .valid  (w_map_valid),
    .a_pmem (w_map_addr)
  );

  assign w_acc_win  = (r_state == S_EXEC) || (r_state == S_DRAIN);
  assign w_consume  = w_acc_win && ofifo_valid && !r_nij_full;
  assign w_overread = w_acc_win && ofifo_valid && r_nij_full;
  assign w_wrow     = c_a_w'(WBASE) + c_a_w'(r_kij) * c_a_w'(COL);
  assign w_wofs     = (r_cyc >= c_wrow_last) ? c_wrow_last : r_cyc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CLR;
      S_CLR:   if (r_cyc == c_clr_end) w_state_nxt = S_WPRE;
      S_WPRE:  w_state_nxt = S_W2L0;
      S_W2L0:  if (r_cyc == c_w2l0_end) w_state_nxt = S_KPRE;
      S_KPRE:  w_state_nxt = S_KLOAD;
      S_KLOAD: if (r_cyc == c_kload_end) w_state_nxt = S_GAP;
      S_GAP:   if (r_cyc == c_gap_end) w_state_nxt = S_XPRE;
      S_XPRE:  w_state_nxt = S_EXEC;
      S_EXEC:  if (r_cyc == c_exec_end) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_cyc == c_drain_end) w_state_nxt = (r_kij == c_kij_last) ? S_DONE : S_CLR;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inst     = c_inst_idle;
    core_clr = 1'b0;
    busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    done     = (r_state == S_DONE);
    err      = r_err;
    case (r_state)
      S_CLR: core_clr = (r_cyc < c_clr_end);
      S_WPRE: begin
        inst[c_b_cen_xmem]               = 1'b0;
        inst[c_b_axmem_lo +: c_a_w]      = w_wrow;
      end
      S_W2L0: begin
        inst[c_b_l0_wr]                  = 1'b1;
        inst[c_b_cen_xmem]               = 1'b0;
        inst[c_b_axmem_lo +: c_a_w]      = w_wrow + c_a_w'(w_wofs);
      end
      S_KPRE: inst[c_b_l0_rd] = 1'b1;
      S_KLOAD: begin
        inst[c_b_l0_rd] = 1'b1;
        inst[c_b_load]  = 1'b1;
      end
      S_XPRE: begin
        inst[c_b_l0_wr]    = 1'b1;
        inst[c_b_l0_rd]    = 1'b1;
        inst[c_b_cen_xmem] = 1'b0;
      end
      S_EXEC: begin
        if (r_cyc < c_nij) begin
          inst[c_b_l0_wr]             = 1'b1;
          inst[c_b_l0_rd]             = 1'b1;
          inst[c_b_execute]           = 1'b1;
          inst[c_b_cen_xmem]          = 1'b0;
          inst[c_b_axmem_lo +: c_a_w] = c_a_w'(r_cyc) + c_a_w'(1);
        end
      end
      default: ;
    endcase
    // Same-cycle OFIFO read: the pop lands on the edge that sees valid.
    if (w_acc_win && ofifo_valid) begin
      inst[c_b_ofifo_rd] = 1'b1;
      if (!r_nij_full) begin
        inst[c_b_cen_pmem] = !w_map_valid;
        inst[c_b_wen_pmem] = w_map_valid;
        inst[c_b_apmem_lo +: c_a_w] = w_map_addr;
        inst[c_b_sfu_pass] = (r_kij == '0);
        inst[c_b_acc]      = (r_kij != '0);
        inst[c_b_relu]     = r_relu_en && (r_kij == c_kij_last);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_kij      <= '0;
      r_nx       <= '0;
      r_ny       <= '0;
      r_nij_full <= 1'b0;
      r_err      <= 1'b0;
      r_relu_en  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_cyc <= '0;
      else                                                 r_cyc <= r_cyc + CW'(1);

      if (r_state == S_IDLE && start) begin
        r_kij     <= '0;
        r_err     <= 1'b0;
        r_relu_en <= relu_en;
      end
      if (r_state == S_DRAIN && w_state_nxt == S_CLR) r_kij <= r_kij + KIJ_W'(1);

      if (w_state_nxt == S_XPRE && r_state != S_XPRE) begin
        r_nx       <= '0;
        r_ny       <= '0;
        r_nij_full <= 1'b0;
      end else if (w_consume) begin
        if (r_nx == c_xy_last) begin
          r_nx <= '0;
          if (r_ny == c_xy_last) r_nij_full <= 1'b1;
          else                   r_ny       <= r_ny + XY_W'(1);
        end else begin
          r_nx <= r_nx + XY_W'(1);
        end
      end
      if (w_overread) r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_conv_seq_ctrl : directed bench for the convolution tile sequencer        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_conv_seq_ctrl;

  localparam logic [63:0] IDLE_INST = 64'h0000_0001_000C_0000;
  localparam int KIJ_LEN = 106;
  localparam int RUN_LEN = 954;
  localparam int EXEC0   = 51;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [63:0] inst;
  logic        core_clr, busy, done, err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .relu_en     (relu_en),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_clr    (core_clr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  function automatic logic [10:0] a_xmem(input logic [63:0] w); return w[17:7];  endfunction
  function automatic logic [10:0] a_pmem(input logic [63:0] w); return w[30:20]; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      ofifo_valid = 1'b0;
      tick();
    end
  endtask

  // After this returns, cyc==0 is the first CLR cycle.
  task automatic do_start(input logic relu);
    start   = 1'b1;
    relu_en = relu;
    tick();
    start   = 1'b0;
    cyc     = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    #1;
    checks++; if (inst !== IDLE_INST) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, IDLE_INST); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (core_clr !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0", core_clr); end
  endtask

  task automatic test_full_run();
    int load_cnt = 0, xbad = 0, pmem_bad = 0, early_done = 0;
    int k, o;
    logic [10:0] exp_a;
    do_start(1'b0);
    #1;
    checks++; if ({core_clr, busy} !== 2'b11) begin failures++; $display("FAIL first_clr got clr=%b busy=%b exp 1 1", core_clr, busy); end
    for (int c = 0; c < RUN_LEN; c++) begin
      if (c != 0) #1;
      if (done) early_done++;
      if (inst[32] !== 1'b1) pmem_bad++;
      k = c / KIJ_LEN;
      o = c % KIJ_LEN;
      if (k == 2) begin
        if (inst[0]) load_cnt++;
        if (o == 12 && (a_xmem(inst) !== 11'd1040 || inst[19] !== 1'b0)) xbad++;
        if (o >= 13 && o <= 21) begin
          exp_a = 11'd1040 + 11'((o - 13 > 7) ? 7 : o - 13);
          if (a_xmem(inst) !== exp_a || inst[2] !== 1'b1 || inst[19] !== 1'b0) xbad++;
        end
      end
      tick();
    end
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_at_954 got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done got=%b exp=0", busy); end
    checks++; if (early_done !== 0) begin failures++; $display("FAIL early_done got=%0d exp=0", early_done); end
    checks++; if (load_cnt !== 16) begin failures++; $display("FAIL kij2_load_cycles got=%0d exp=16", load_cnt); end
    checks++; if (xbad !== 0) begin failures++; $display("FAIL kij2_axmem_bad got=%0d exp=0", xbad); end
    checks++; if (pmem_bad !== 0) begin failures++; $display("FAIL pmem_active_no_valid got=%0d exp=0", pmem_bad); end
    tick();
    #1;
    checks++; if ({inst, done} !== {IDLE_INST, 1'b0}) begin failures++; $display("FAIL after_done_idle got=%h/%b exp=%h/0", inst, done, IDLE_INST); end
  endtask

  task automatic test_accumulate();
    do_start(1'b0);
    // kij 0, single beat at nij 0 -> passthrough write to address 0
    go_to(EXEC0 + 5);
    ofifo_valid = 1'b1;
    #1;
    checks++; if ({inst[6], inst[32], inst[31], a_pmem(inst), inst[34], inst[33]} !== {1'b1, 1'b0, 1'b1, 11'd0, 1'b1, 1'b0})
      begin failures++; $display("FAIL kij0_pass got rd=%b cen=%b wen=%b a=%0d pass=%b acc=%b exp 1 0 1 0 1 0", inst[6], inst[32], inst[31], a_pmem(inst), inst[34], inst[33]); end
    tick();
    ofifo_valid = 1'b0;
    // kij 4, 36 beats from EXEC t=8
    go_to(4 * KIJ_LEN + EXEC0 + 8);
    for (int n = 0; n < 36; n++) begin
      ofifo_valid = 1'b1;
      #1;
      if (n == 6) begin
        checks++; if ({inst[6], inst[32], inst[31]} !== 3'b110) begin failures++; $display("FAIL kij4_nij6 got rd=%b cen=%b wen=%b exp 1 1 0", inst[6], inst[32], inst[31]); end
      end
      if (n >= 7 && n <= 10) begin
        checks++; if ({inst[32], inst[31], a_pmem(inst)} !== {1'b0, 1'b1, 11'(n - 7)}) begin failures++; $display("FAIL kij4_nij%0d got cen=%b wen=%b a=%0d exp 0 1 %0d", n, inst[32], inst[31], a_pmem(inst), n - 7); end
      end
      if (n == 7) begin
        checks++; if ({inst[33], inst[34], inst[45]} !== 3'b100) begin failures++; $display("FAIL kij4_acc got acc=%b pass=%b relu=%b exp 1 0 0", inst[33], inst[34], inst[45]); end
      end
      if (n == 25) begin
        checks++; if ({inst[32], a_pmem(inst)} !== {1'b0, 11'd12}) begin failures++; $display("FAIL kij4_nij25 got cen=%b a=%0d exp 0 12", inst[32], a_pmem(inst)); end
      end
      tick();
    end
    ofifo_valid = 1'b0;
    // kij 5, 37 beats: the last one is an over-read
    go_to(5 * KIJ_LEN + EXEC0);
    for (int n = 0; n < 37; n++) begin
      ofifo_valid = 1'b1;
      #1;
      if (n == 35) begin
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_before_overread got=%b exp=0", err); end
      end
      if (n == 36) begin
        checks++; if ({inst[6], inst[32]} !== 2'b11) begin failures++; $display("FAIL overread_beat got rd=%b cen=%b exp 1 1", inst[6], inst[32]); end
      end
      tick();
    end
    ofifo_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_rise got=%b exp=1", err); end
    // kij 8 without relu_en: nij 14 maps to address 0
    go_to(8 * KIJ_LEN + EXEC0);
    for (int n = 0; n < 15; n++) begin
      ofifo_valid = 1'b1;
      #1;
      if (n == 14) begin
        checks++; if ({inst[32], a_pmem(inst), inst[45]} !== {1'b0, 11'd0, 1'b0}) begin failures++; $display("FAIL kij8_norelu got cen=%b a=%0d relu=%b exp 0 0 0", inst[32], a_pmem(inst), inst[45]); end
      end
      tick();
    end
    go_to(RUN_LEN);
    #1;
    checks++; if ({done, err} !== 2'b11) begin failures++; $display("FAIL err_sticky_at_done got done=%b err=%b exp 1 1", done, err); end
    tick();
  endtask

  task automatic test_relu();
    do_start(1'b1);
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared_by_start got=%b exp=0", err); end
    go_to(8 * KIJ_LEN + EXEC0);
    for (int n = 0; n < 15; n++) begin
      ofifo_valid = 1'b1;
      #1;
      if (n == 14) begin
        checks++; if ({inst[32], inst[31], inst[45], inst[33], inst[34]} !== 5'b01110) begin failures++; $display("FAIL kij8_relu got cen=%b wen=%b relu=%b acc=%b pass=%b exp 0 1 1 1 0", inst[32], inst[31], inst[45], inst[33], inst[34]); end
      end
      tick();
    end
    go_to(RUN_LEN);
    tick();
  endtask

  task automatic test_reset_midrun();
    do_start(1'b0);
    go_to(KIJ_LEN + EXEC0);
    for (int n = 0; n < 37; n++) begin
      ofifo_valid = 1'b1;
      tick();
    end
    ofifo_valid = 1'b0;
    go_to(3 * KIJ_LEN + 23 + 3);
    #1;
    checks++; if ({inst[0], err} !== 2'b11) begin failures++; $display("FAIL pre_reset_kload got load=%b err=%b exp 1 1", inst[0], err); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (inst !== IDLE_INST) begin failures++; $display("FAIL midreset_inst got=%h exp=%h", inst, IDLE_INST); end
    checks++; if ({busy, done, core_clr, err} !== 4'b0000) begin failures++; $display("FAIL midreset_flags got busy=%b done=%b clr=%b err=%b exp 0 0 0 0", busy, done, core_clr, err); end
    repeat (5) tick();
    #1;
    checks++; if ({inst, busy} !== {IDLE_INST, 1'b0}) begin failures++; $display("FAIL midreset_quiet got=%h busy=%b exp=%h 0", inst, busy, IDLE_INST); end
    do_start(1'b0);
    go_to(12);
    #1;
    checks++; if ({a_xmem(inst), inst[19]} !== {11'd1024, 1'b0}) begin failures++; $display("FAIL restart_wpre got a=%0d cen=%b exp 1024 0", a_xmem(inst), inst[19]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_accumulate();
    test_relu();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
